// File: rtl/crc_frame_ctrl.sv
// Byte-stream front end for a bit-serial CRC engine.
// Words arrive on a valid/ready stream, are serialised one bit per clock into
// the engine, and the final CRC plus word count are reported with a one-cycle
// crc_valid pulse when the word flagged last has been shifted in.

// Bit-serial CRC engine: non-reflected register, one input bit per valid cycle.
module crc_dynamic #(
    parameter int CRC_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic                data_in,
    input  logic [CRC_SIZE-1:0] initial_value,
    input  logic [CRC_SIZE-1:0] crc_poly,
    input  logic [CRC_SIZE-1:0] final_xor,
    output logic [CRC_SIZE-1:0] crc_out
);

    logic [CRC_SIZE-1:0] crc_q;
    logic                feedback;

    assign feedback = crc_q[CRC_SIZE-1] ^ data_in;
    assign crc_out  = crc_q ^ final_xor;

    // CRC register: reload while in reset, advance one bit per valid cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= initial_value;
        end else if (valid) begin
            crc_q <= {crc_q[CRC_SIZE-2:0], 1'b0} ^ (feedback ? crc_poly : '0);
        end
    end

endmodule

// Framing controller.
//   state    | meaning
//   ST_IDLE  | no frame; engine held at cfg_init; ready for first word
//   ST_SHIFT | serialising the current word, one bit per cycle
//   ST_WAIT  | between words of a frame; engine CRC held
//   ST_DONE  | last word shifted; result captured on exit
module crc_frame_ctrl #(
    parameter int CRC_SIZE = 16,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CRC_SIZE-1:0] cfg_init,
    input  logic [CRC_SIZE-1:0] cfg_poly,
    input  logic [CRC_SIZE-1:0] cfg_xor,
    input  logic                cfg_lsb_first,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    input  logic                abort,
    output logic                busy,
    output logic                crc_valid,
    output logic [CRC_SIZE-1:0] crc_result,
    output logic [CNT_W-1:0]    byte_count
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q;
    logic [BW-1:0]       bit_cnt_q;
    logic                last_q;
    logic [CNT_W-1:0]    count_q;
    logic [CRC_SIZE-1:0] poly_q;
    logic [CRC_SIZE-1:0] xor_q;
    logic                lsb_q;
    logic                crc_valid_q;
    logic [CRC_SIZE-1:0] crc_result_q;
    logic [CNT_W-1:0]    byte_count_q;

    logic                accept;
    logic                done_exit;
    logic                eng_rst;
    logic                eng_valid;
    logic                eng_bit;
    logic [CRC_SIZE-1:0] eng_crc;

    // Next-state logic and stream-side decodes
    always_comb begin
        state_d   = state_q;
        s_ready   = 1'b0;
        accept    = 1'b0;
        done_exit = 1'b0;
        eng_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                accept  = s_valid && !abort;
                if (accept) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                eng_valid = 1'b1;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == '0) begin
                    state_d = last_q ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                s_ready = 1'b1;
                accept  = s_valid && !abort;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                done_exit = !abort;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Word shift register and per-word bit down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            last_q    <= 1'b0;
        end else if (accept) begin
            shift_q   <= s_data;
            bit_cnt_q <= BW'(DATA_W - 1);
            last_q    <= s_last;
        end else if (state_q == ST_SHIFT) begin
            shift_q <= lsb_q ? (shift_q >> 1) : (shift_q << 1);
            if (bit_cnt_q != '0) bit_cnt_q <= bit_cnt_q - 1'b1;
        end
    end

    // Frame configuration snapshot and saturating word count
    always_ff @(posedge clk) begin
        if (rst) begin
            poly_q  <= '0;
            xor_q   <= '0;
            lsb_q   <= 1'b0;
            count_q <= '0;
        end else if (accept && state_q == ST_IDLE) begin
            poly_q  <= cfg_poly;
            xor_q   <= cfg_xor;
            lsb_q   <= cfg_lsb_first;
            count_q <= CNT_W'(1);
        end else if (accept && count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Result capture and one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_valid_q  <= 1'b0;
            crc_result_q <= '0;
            byte_count_q <= '0;
        end else begin
            crc_valid_q <= done_exit;
            if (done_exit) begin
                crc_result_q <= eng_crc;
                byte_count_q <= count_q;
            end
        end
    end

    // Engine is reloaded from live cfg_init whenever no frame is open, so the
    // first-word handshake edge leaves it holding the value seen on that edge.
    assign eng_rst = rst || (state_q == ST_IDLE);
    assign eng_bit = lsb_q ? shift_q[0] : shift_q[DATA_W-1];

    crc_dynamic #(
        .CRC_SIZE (CRC_SIZE)
    ) u_engine (
        .clk           (clk),
        .rst           (eng_rst),
        .valid         (eng_valid),
        .data_in       (eng_bit),
        .initial_value (cfg_init),
        .crc_poly      (poly_q),
        .final_xor     (xor_q),
        .crc_out       (eng_crc)
    );

    assign busy       = (state_q != ST_IDLE);
    assign crc_valid  = crc_valid_q;
    assign crc_result = crc_result_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Self-checking bench for crc_frame_ctrl with a byte-wise CRC reference model.
module tb_crc_frame_ctrl;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] cfg_init = '0, cfg_poly = '0, cfg_xor = '0;
    logic        cfg_lsb_first = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0, s_last = 1'b0, abort = 1'b0;
    logic        s_ready, busy, crc_valid;
    logic [15:0] crc_result, byte_count;
    logic        s_ready_s, busy_s, crc_valid_s;
    logic [15:0] crc_result_s;
    logic [1:0]  byte_count_s;

    int          n_checks = 0, n_pass = 0;
    int          cyc = 0, pulse_cyc = 0;
    logic [31:0] obs[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_frame_ctrl #(.CRC_SIZE(16), .DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cfg_init(cfg_init), .cfg_poly(cfg_poly),
        .cfg_xor(cfg_xor), .cfg_lsb_first(cfg_lsb_first), .s_data(s_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready), .abort(abort),
        .busy(busy), .crc_valid(crc_valid), .crc_result(crc_result),
        .byte_count(byte_count)
    );

    // Narrow-count instance so saturation is reachable in a short run
    crc_frame_ctrl #(.CRC_SIZE(16), .DATA_W(8), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .cfg_init(cfg_init), .cfg_poly(cfg_poly),
        .cfg_xor(cfg_xor), .cfg_lsb_first(cfg_lsb_first), .s_data(s_data),
        .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready_s), .abort(abort),
        .busy(busy_s), .crc_valid(crc_valid_s), .crc_result(crc_result_s),
        .byte_count(byte_count_s)
    );

    always @(negedge clk) begin
        if (crc_valid) begin
            obs.push_back({crc_result, byte_count});
            pulse_cyc = cyc;
        end
    end

    // Reference: classic byte-at-a-time MSB-first CRC; LSB-first words are
    // bit-reversed before entering the register.
    function automatic logic [15:0] model_crc(input bq_t d, input logic [15:0] init,
                                              input logic [15:0] poly, input logic [15:0] xr,
                                              input logic lsb);
        logic [15:0] crc = init;
        logic [7:0]  b;
        foreach (d[i]) begin
            b = d[i];
            if (lsb) b = {<<{b}};
            crc = crc ^ {b, 8'h00};
            for (int k = 0; k < 8; k++)
                crc = crc[15] ? ((crc << 1) ^ poly) : (crc << 1);
        end
        return crc ^ xr;
    endfunction

    function automatic bq_t digits(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(8'h31 + i));
        return q;
    endfunction

    task automatic push(input logic [7:0] d, input logic l);
        int t = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        while (!s_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin
            n_checks++;
            $display("FAIL push_timeout: s_ready=%b required 1", s_ready);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic run_frame(input bq_t d, input int gap_max);
        int g;
        foreach (d[i]) begin
            push(d[i], i == d.size() - 1);
            if (i != d.size() - 1 && gap_max > 0) begin
                g = $urandom_range(gap_max, 0);
                repeat (g) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_pulses(input int n);
        int t = 0;
        while (obs.size() < n && t < 3000) begin @(negedge clk); t++; end
        if (obs.size() < n) begin
            n_checks++;
            $display("FAIL pulse_timeout: pulses=%0d required %0d", obs.size(), n);
        end
    endtask

    task automatic set_cfg(input logic [15:0] i, input logic [15:0] p,
                           input logic [15:0] x, input logic l);
        cfg_init = i; cfg_poly = p; cfg_xor = x; cfg_lsb_first = l;
    endtask

    task automatic test_reset;
        n_checks++;
        if ({s_ready, busy, crc_valid, crc_result, byte_count} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0})
            $display("FAIL reset_state: ready=%b busy=%b valid=%b crc=%h cnt=%0d required 1 0 0 0000 0",
                     s_ready, busy, crc_valid, crc_result, byte_count);
        else n_pass++;
    endtask

    task automatic test_vectors;
        obs.delete();
        set_cfg(16'hFFFF, 16'h1021, 16'h0000, 1'b0);
        run_frame(digits(9), 0);
        wait_pulses(1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs.size() != 1 || obs[0] !== {16'h29B1, 16'd9})
            $display("FAIL ccitt_false: pulses=%0d crc/cnt=%h required 1 29b10009", obs.size(), obs[0]);
        else n_pass++;

        obs.delete();
        set_cfg(16'h0000, 16'h1021, 16'h0000, 1'b1);
        run_frame(digits(9), 0);
        wait_pulses(1);
        n_checks++;
        if (obs[0][31:16] !== 16'h9184)
            $display("FAIL lsb_kermit: crc=%h required 9184", obs[0][31:16]);
        else n_pass++;

        obs.delete();
        set_cfg(16'h0000, 16'h1021, 16'hFFFF, 1'b0);
        push(8'h00, 1'b1);
        begin
            int hs = cyc;
            wait_pulses(1);
            n_checks++;
            if (pulse_cyc !== hs + 9)
                $display("FAIL single_latency: pulse after %0d edges required 9", pulse_cyc - hs);
            else n_pass++;
        end
        n_checks++;
        if (obs[0] !== {16'hFFFF, 16'd1})
            $display("FAIL single_word: crc/cnt=%h required ffff0001", obs[0]);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs.size() != 1 || crc_result !== 16'hFFFF || byte_count !== 16'd1)
            $display("FAIL single_hold: pulses=%0d crc=%h cnt=%0d required 1 ffff 1",
                     obs.size(), crc_result, byte_count);
        else n_pass++;
    endtask

    task automatic test_word_timing;
        obs.delete();
        set_cfg(16'h1D0F, 16'h1021, 16'h0000, 1'b0);
        push(8'hA5, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        n_checks++;
        if (s_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL shift_ready: ready=%b busy=%b after E7 required 0 1", s_ready, busy);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (s_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL wait_ready: ready=%b busy=%b after E8 required 1 1", s_ready, busy);
        else n_pass++;
        push(8'h5A, 1'b1);
        wait_pulses(1);
        begin
            bq_t q = '{8'hA5, 8'h5A};
            n_checks++;
            if (obs[0] !== {model_crc(q, 16'h1D0F, 16'h1021, 16'h0, 1'b0), 16'd2})
                $display("FAIL two_word: crc/cnt=%h required %h", obs[0],
                         {model_crc(q, 16'h1D0F, 16'h1021, 16'h0, 1'b0), 16'd2});
            else n_pass++;
        end
    endtask

    task automatic test_gaps;
        bq_t         q = digits(5);
        logic [31:0] ref_obs;
        logic        ready_ok = 1'b1;
        obs.delete();
        set_cfg(16'hFFFF, 16'h8005, 16'h0000, 1'b1);
        run_frame(q, 0);
        wait_pulses(1);
        ref_obs = obs[0];
        obs.delete();
        foreach (q[i]) begin
            push(q[i], i == 4);
            if (i != 4) begin
                repeat (9) @(posedge clk);
                cfg_init = 16'($urandom); cfg_poly = 16'($urandom);
                for (int g = 0; g < 20; g++) begin
                    @(negedge clk);
                    if (s_ready !== 1'b1) ready_ok = 1'b0;
                end
            end
        end
        wait_pulses(1);
        n_checks++;
        if (!ready_ok) $display("FAIL gap_ready: s_ready dropped in WAIT required 1");
        else n_pass++;
        n_checks++;
        if (obs[0] !== ref_obs || ref_obs !== {model_crc(q, 16'hFFFF, 16'h8005, 16'h0, 1'b1), 16'd5})
            $display("FAIL gap_result: gapped=%h ungapped=%h required %h", obs[0], ref_obs,
                     {model_crc(q, 16'hFFFF, 16'h8005, 16'h0, 1'b1), 16'd5});
        else n_pass++;
        cfg_poly = 16'h8005;
    endtask

    task automatic test_abort;
        logic [15:0] prev_crc = crc_result, prev_cnt = byte_count;
        obs.delete();
        set_cfg(16'hFFFF, 16'h1021, 16'h0000, 1'b0);
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        push(8'h33, 1'b1);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy: busy=%b required 0", busy);
        else n_pass++;
        repeat (12) @(negedge clk);
        n_checks++;
        if (obs.size() != 0 || crc_result !== prev_crc || byte_count !== prev_cnt)
            $display("FAIL abort_quiet: pulses=%0d crc=%h cnt=%0d required 0 %h %0d",
                     obs.size(), crc_result, byte_count, prev_crc, prev_cnt);
        else n_pass++;

        #1 s_data = 8'h77; s_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1 s_valid = 1'b0; abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_idle: busy=%b required 0", busy);
        else n_pass++;

        run_frame(digits(9), 0);
        wait_pulses(1);
        n_checks++;
        if (obs[0] !== {16'h29B1, 16'd9})
            $display("FAIL after_abort: crc/cnt=%h required 29b10009", obs[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        bq_t q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        obs.delete();
        set_cfg(16'h1234, 16'h3D65, 16'hA5A5, 1'b1);
        push(8'h41, 1'b0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({s_ready, busy, crc_valid, crc_result, byte_count} !== {1'b1, 1'b0, 1'b0, 16'h0, 16'h0})
            $display("FAIL reset_mid: ready=%b busy=%b valid=%b crc=%h cnt=%0d required 1 0 0 0000 0",
                     s_ready, busy, crc_valid, crc_result, byte_count);
        else n_pass++;
        rst = 1'b0;
        run_frame(q, 2);
        wait_pulses(1);
        n_checks++;
        if (obs[0] !== {model_crc(q, 16'h1234, 16'h3D65, 16'hA5A5, 1'b1), 16'd4})
            $display("FAIL reset_next: crc/cnt=%h required %h", obs[0],
                     {model_crc(q, 16'h1234, 16'h3D65, 16'hA5A5, 1'b1), 16'd4});
        else n_pass++;
    endtask

    task automatic test_saturation;
        bq_t q = digits(5);
        obs.delete();
        set_cfg(16'hFFFF, 16'h1021, 16'h0000, 1'b0);
        run_frame(q, 0);
        wait_pulses(1);
        n_checks++;
        if (byte_count !== 16'd5 || byte_count_s !== 2'd3 || crc_result_s !== crc_result
            || busy_s !== busy || s_ready_s !== s_ready || crc_valid_s !== crc_valid)
            $display("FAIL count_sat: wide=%0d narrow=%0d crc_s=%h crc=%h required 5 3 equal",
                     byte_count, byte_count_s, crc_result_s, crc_result);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] expq[$];
        obs.delete();
        for (int f = 0; f < 6; f++) begin
            bq_t         q;
            logic [15:0] i = 16'($urandom), p = 16'($urandom) | 16'h1, x = 16'($urandom);
            logic        l = 1'($urandom);
            int          n = $urandom_range(6, 1);
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            expq.push_back({model_crc(q, i, p, x, l), 16'(n)});
            set_cfg(i, p, x, l);
            foreach (q[k]) begin
                push(q[k], k == n - 1);
                if (k == 0) begin
                    cfg_poly = 16'($urandom); cfg_xor = 16'($urandom);
                    cfg_lsb_first = ~l;
                end
                if (k != n - 1) begin
                    repeat ($urandom_range(3, 0)) @(posedge clk);
                    #1;
                end
            end
        end
        wait_pulses(6);
        foreach (expq[f]) begin
            n_checks++;
            if (obs.size() <= f || obs[f] !== expq[f])
                $display("FAIL b2b_frame%0d: crc/cnt=%h required %h", f,
                         (obs.size() > f) ? obs[f] : 32'hx, expq[f]);
            else n_pass++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_vectors;
        test_word_timing;
        test_gaps;
        test_abort;
        test_reset_mid;
        test_saturation;
        test_back_to_back;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
